// File: rtl/wrreq_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : wrreq_arb_pkg                                                |
// | Description : Shared types and helpers for the weighted round-robin write  |
// |               request arbiter: FSM state encoding and the cyclic           |
// |               first-set search used by the request picker.                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package wrreq_arb_pkg;

  localparam int MAX_CH    = 16;
  localparam int MAX_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_SEL_W-1:0] idx;
  } pick_t;

  // First set bit of req found cyclically starting at ptr, over n channels.
  // The scan runs from the far end back towards ptr so the last hit written
  // is the nearest one, which keeps the loop free of early exits.
  function automatic pick_t rr_first(input logic [MAX_CH-1:0]    req,
                                     input logic [MAX_SEL_W-1:0] ptr,
                                     input int                   n);
    pick_t                res;
    logic [MAX_SEL_W:0]   sum;
    logic [MAX_SEL_W-1:0] idx;
    res = '0;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        sum = {1'b0, ptr} + (MAX_SEL_W+1)'(k);
        if (sum >= (MAX_SEL_W+1)'(n)) begin
          sum = sum - (MAX_SEL_W+1)'(n);
        end
        idx = sum[MAX_SEL_W-1:0];
        if (req[idx]) begin
          res.valid = 1'b1;
          res.idx   = idx;
        end
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wrreq_arb_wrr_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : wrreq_arb_wrr_if                                             |
// | Description : Client-side and core-side write request bus of the arbiter.  |
// |   master : arbiter view  (clients/core inputs in, routed results out)      |
// |   slave  : environment view (clients and DDR3 core)                        |
// |   Client side : wr_req_, wr_addr_, wr_num_, wr_data_, weight_ (packed per  |
// |                 channel), wr_grant_, wr_finish_ (routed back)              |
// |   Core side   : wr_req, wr_addr, wr_num, wr_data, wr_grant, wr_finish      |
// |   Status      : arb_sel (owner index), arb_busy                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface wrreq_arb_wrr_if #(
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_ADDR_WIDTH = 28,
  parameter int CHANNEL_NUM    = 3,
  parameter int NUM_WIDTH      = 10,
  parameter int WEIGHT_WIDTH   = 4
);
  localparam int SEL_W = $clog2(CHANNEL_NUM);

  logic [CHANNEL_NUM-1:0]                wr_req_;
  logic [APP_ADDR_WIDTH*CHANNEL_NUM-1:0] wr_addr_;
  logic [NUM_WIDTH*CHANNEL_NUM-1:0]      wr_num_;
  logic [APP_DATA_WIDTH*CHANNEL_NUM-1:0] wr_data_;
  logic [WEIGHT_WIDTH*CHANNEL_NUM-1:0]   weight_;
  logic [CHANNEL_NUM-1:0]                wr_grant_;
  logic [CHANNEL_NUM-1:0]                wr_finish_;
  logic                                  wr_req;
  logic [APP_ADDR_WIDTH-1:0]             wr_addr;
  logic [NUM_WIDTH-1:0]                  wr_num;
  logic [APP_DATA_WIDTH-1:0]             wr_data;
  logic                                  wr_grant;
  logic                                  wr_finish;
  logic [SEL_W-1:0]                      arb_sel;
  logic                                  arb_busy;

  modport master (
    input  wr_req_, wr_addr_, wr_num_, wr_data_, weight_, wr_grant, wr_finish,
    output wr_grant_, wr_finish_, wr_req, wr_addr, wr_num, wr_data, arb_sel, arb_busy
  );

  modport slave (
    output wr_req_, wr_addr_, wr_num_, wr_data_, weight_, wr_grant, wr_finish,
    input  wr_grant_, wr_finish_, wr_req, wr_addr, wr_num, wr_data, arb_sel, arb_busy
  );

endinterface
`default_nettype wire

// File: rtl/wrreq_arb_wrr_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_pick                                                      |
// | Description : Combinational cyclic priority picker. Returns the first set  |
// |               request at or after ptr (wrapping) and a valid flag.         |
// |   req_i   : request vector, CHANNEL_NUM bits                               |
// |   ptr_i   : search start index                                             |
// |   idx_o   : winning channel index                                          |
// |   valid_o : high when any request is set                                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rr_pick #(
  parameter int CHANNEL_NUM = 3,
  parameter int SEL_W       = $clog2(CHANNEL_NUM)
) (
  input  logic [CHANNEL_NUM-1:0] req_i,
  input  logic [SEL_W-1:0]       ptr_i,
  output logic [SEL_W-1:0]       idx_o,
  output logic                   valid_o
);
  import wrreq_arb_pkg::*;

  logic [MAX_CH-1:0]    w_req_pad;
  logic [MAX_SEL_W-1:0] w_ptr_pad;
  pick_t                w_pick;
  logic                 w_unused_idx;

  always_comb begin
    w_req_pad                  = '0;
    w_req_pad[CHANNEL_NUM-1:0] = req_i;
    w_ptr_pad                  = '0;
    w_ptr_pad[SEL_W-1:0]       = ptr_i;
    w_pick                     = rr_first(w_req_pad, w_ptr_pad, CHANNEL_NUM);
  end

  assign idx_o        = w_pick.idx[SEL_W-1:0];
  assign valid_o      = w_pick.valid;
  // Index bits above SEL_W are always zero for a legal channel count.
  assign w_unused_idx = ^w_pick.idx;

endmodule
`default_nettype wire

// File: rtl/wrreq_arb_wrr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wrreq_arb_wrr                                                |
// | Description : Weighted round-robin arbiter of CHANNEL_NUM write clients    |
// |               onto the single write port of the DDR3 core. Winner request, |
// |               address and burst count are registered; per-beat grant and   |
// |               finish are routed back to the owner only while BUSY.         |
// |   clk, rst   : clock, synchronous active-high reset                        |
// |   bus        : wrreq_arb_wrr_if.master (client, core and status signals)   |
// |   grant_cnt_ : per-channel saturating finish counters (32 bits each),      |
// |                present only when WRREQ_ARB_STAT_EN is defined              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module wrreq_arb_wrr #(
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_ADDR_WIDTH = 28,
  parameter int CHANNEL_NUM    = 3,
  parameter int NUM_WIDTH      = 10,
  parameter int WEIGHT_WIDTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  wrreq_arb_wrr_if.master bus
`ifdef WRREQ_ARB_STAT_EN
  ,
  output logic [32*CHANNEL_NUM-1:0] grant_cnt_
`endif
);
  import wrreq_arb_pkg::*;

  localparam int SEL_W = $clog2(CHANNEL_NUM);

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [SEL_W-1:0]          ptr_q, ptr_d;
  logic                      req_q, req_d;
  logic [APP_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_WIDTH-1:0]      num_q, num_d;
  logic [WEIGHT_WIDTH-1:0]   cnt_q [CHANNEL_NUM];
  logic [WEIGHT_WIDTH-1:0]   cnt_d [CHANNEL_NUM];

  logic [SEL_W-1:0]          w_pick_idx;
  logic                      w_pick_valid;
  logic [WEIGHT_WIDTH-1:0]   w_wt;
  logic [WEIGHT_WIDTH:0]     w_wt_eff;
  logic [WEIGHT_WIDTH:0]     w_cnt_inc;
  logic [SEL_W-1:0]          w_sel_nxt;
  logic                      w_busy;
  logic                      w_fin;

  rr_pick #(
    .CHANNEL_NUM (CHANNEL_NUM),
    .SEL_W       (SEL_W)
  ) u_pick (
    .req_i   (bus.wr_req_),
    .ptr_i   (ptr_q),
    .idx_o   (w_pick_idx),
    .valid_o (w_pick_valid)
  );

  assign w_busy = (state_q == BUSY);
  assign w_fin  = w_busy && bus.wr_finish;

  // Weight is read live so a change lands at the next finish comparison;
  // a zero weight still grants one burst per turn.
  assign w_wt      = bus.weight_[int'(sel_q)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign w_wt_eff  = (w_wt == '0) ? (WEIGHT_WIDTH+1)'(1) : {1'b0, w_wt};
  assign w_cnt_inc = {1'b0, cnt_q[sel_q]} + (WEIGHT_WIDTH+1)'(1);
  assign w_sel_nxt = (sel_q == SEL_W'(CHANNEL_NUM - 1)) ? '0 : sel_q + 1'b1;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    req_d   = req_q;
    addr_d  = addr_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (w_pick_valid) begin
          sel_d   = w_pick_idx;
          req_d   = 1'b1;
          addr_d  = bus.wr_addr_[int'(w_pick_idx)*APP_ADDR_WIDTH +: APP_ADDR_WIDTH];
          num_d   = bus.wr_num_[int'(w_pick_idx)*NUM_WIDTH +: NUM_WIDTH];
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A request dropped mid-burst is ignored; only finish ends BUSY.
        if (bus.wr_finish) begin
          req_d   = 1'b0;
          state_d = GAP;
          if (w_cnt_inc >= w_wt_eff) begin
            cnt_d[sel_q] = '0;
            ptr_d        = w_sel_nxt;
          end else begin
            cnt_d[sel_q] = w_cnt_inc[WEIGHT_WIDTH-1:0];
            ptr_d        = sel_q;
          end
        end
      end
      GAP: begin
        // One idle cycle lets the finished client drop its request.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      num_q   <= '0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      num_q   <= num_d;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.wr_req    = req_q;
  assign bus.wr_addr   = addr_q;
  assign bus.wr_num    = num_q;
  assign bus.wr_data   = bus.wr_data_[int'(sel_q)*APP_DATA_WIDTH +: APP_DATA_WIDTH];
  assign bus.arb_sel   = sel_q;
  assign bus.arb_busy  = w_busy;
  assign bus.wr_grant_ = w_busy ? ({{(CHANNEL_NUM-1){1'b0}}, bus.wr_grant} << sel_q) : '0;
  assign bus.wr_finish_= w_busy ? ({{(CHANNEL_NUM-1){1'b0}}, bus.wr_finish} << sel_q) : '0;

`ifdef WRREQ_ARB_STAT_EN
  generate
    for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_stat
      logic [31:0] stat_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          stat_q <= '0;
        end else if (w_fin && (sel_q == SEL_W'(i)) && (stat_q != '1)) begin
          stat_q <= stat_q + 32'd1;
        end
      end
      assign grant_cnt_[32*i +: 32] = stat_q;
    end
  endgenerate
`endif

endmodule
`default_nettype wire
